// File: rtl/sample_scheduler_pkg.sv
// sample_scheduler_pkg: sample-word field positions, FSM encodings and channel-select width
package sample_scheduler_pkg;
    localparam int CNT_MSB = 31;
    localparam int CNT_LSB = 16;
    localparam int POS_MSB = 15;
    localparam int POS_LSB = 1;
    localparam int BIT = 0;
    localparam int CHANNEL_SEL_W = 8;
    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        ISSUE   = 3'b010,
        CAPTURE = 3'b100
    } state_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: first-word-fall-through FIFO with sync clear and occupancy count
module sample_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == (AW + 1)'(DEPTH);
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end
endmodule

// File: rtl/sample_scheduler.sv
// sample_scheduler: round-robin poller of the pin sample bus that queues only fresh samples
module sample_scheduler
    import sample_scheduler_pkg::*;
#(
    parameter int NUM_CHANNELS = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [NUM_CHANNELS-1:0]       channel_mask,
    output logic                          output_sample,
    output logic [CHANNEL_SEL_W-1:0]      channel_select,
    input  logic [31:0]                   sample_data,
    input  logic                          fifo_rd,
    output logic [31:0]                   fifo_data,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          busy
);
    localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    state_t state;
    logic [CHANNEL_SEL_W-1:0] ptr, first_ptr, next_ptr;
    logic [15:0] last_cnt [NUM_CHANNELS];
    logic run, is_new, push;

    function automatic logic [CHANNEL_SEL_W-1:0] find_set(
        input logic [NUM_CHANNELS-1:0] mask,
        input logic [CHANNEL_SEL_W-1:0] start,
        input logic skip
    );
        logic [CHANNEL_SEL_W-1:0] r;
        logic hit;
        int idx;
        r = start;
        hit = 1'b0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            idx = (int'(start) + k + int'(skip)) % NUM_CHANNELS;
            if (!hit && mask[IW'(idx)]) begin
                r = CHANNEL_SEL_W'(idx);
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        run = enable && |channel_mask;
        first_ptr = find_set(channel_mask, ptr, 1'b0);
        next_ptr = find_set(channel_mask, ptr, 1'b1);
        is_new = state == CAPTURE
            && sample_data[POS_MSB:POS_LSB] == 15'(ptr)
            && sample_data[CNT_MSB:CNT_LSB] != last_cnt[IW'(ptr)];
        push = is_new && !fifo_full && !clear;
        busy = state != IDLE;
    end

    // ptr survives clear so polling resumes where it left off
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr <= '0;
            output_sample <= 1'b0;
            channel_select <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) last_cnt[i] <= '0;
        end else if (clear) begin
            state <= IDLE;
            output_sample <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) last_cnt[i] <= '0;
        end else begin
            case (state)
                IDLE: if (run) begin
                    ptr <= first_ptr;
                    channel_select <= first_ptr;
                    output_sample <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: begin
                    output_sample <= 1'b0;
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    if (push) last_cnt[IW'(ptr)] <= sample_data[CNT_MSB:CNT_LSB];
                    if (is_new && fifo_full) overflow <= 1'b1;
                    ptr <= next_ptr;
                    channel_select <= run ? next_ptr : channel_select;
                    output_sample <= run;
                    state <= run ? ISSUE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .pop   (fifo_rd),
        .din   (sample_data),
        .dout  (fifo_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_sample_scheduler.sv
// tb_sample_scheduler: pincontrol-bus model plus transaction-level reference for the sample scheduler
module tb_sample_scheduler;
    localparam int N = 4;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic clear = 1'b0;
    logic fifo_rd = 1'b0;
    logic [N-1:0] channel_mask = '0;
    logic [31:0] sample_data = '0;
    logic output_sample, fifo_empty, fifo_full, overflow, busy;
    logic [7:0] channel_select;
    logic [31:0] fifo_data;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    sample_scheduler #(.NUM_CHANNELS(N), .FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .clear          (clear),
        .channel_mask   (channel_mask),
        .output_sample  (output_sample),
        .channel_select (channel_select),
        .sample_data    (sample_data),
        .fifo_rd        (fifo_rd),
        .fifo_data      (fifo_data),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .busy           (busy)
    );

    int total = 0;
    int bad = 0;
    int strobes = 0;
    logic [15:0] cnt_pc [N];
    logic bit_pc [N];
    logic [31:0] q [$];
    logic [15:0] last_m [N];
    logic ovf_m = 1'b0;
    int ptr_m = 0;
    int cap_ch = 0;
    logic pend = 1'b0;
    logic [N-1:0] msk_nx = '0;
    logic en_nx = 1'b0;
    logic bad_pos = 1'b0, zero_bus = 1'b0, clr_now = 1'b0, clr_on_cap = 1'b0;
    logic chk_idle = 1'b0, rd_force = 1'b0, mask_rand = 1'b0;
    int rd_pct = 0;
    int clr_pct = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // smallest set bit at/after p (or strictly after), else the smallest set bit, else p
    function automatic int pick(input logic [N-1:0] m, input int p, input bit after);
        int lo, hi;
        lo = -1;
        hi = -1;
        for (int i = N - 1; i >= 0; i--)
            if (m[i]) begin
                lo = i;
                if (after ? i > p : i >= p) hi = i;
            end
        return hi >= 0 ? hi : (lo >= 0 ? lo : p);
    endfunction

    task automatic model_clear();
        q.delete();
        foreach (last_m[i]) last_m[i] = '0;
        ovf_m = 1'b0;
        pend = 1'b0;
    endtask

    task automatic step();
        logic [31:0] w;
        logic nw, full_pre, cap;
        int ch;
        @(negedge clk);
        chk("count", 32'(fifo_count), q.size());
        chk("empty", 32'(fifo_empty), 32'(q.size() == 0));
        chk("full", 32'(fifo_full), 32'(q.size() == D));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        if (chk_idle) begin
            chk("busy_after_clear", 32'(busy), 0);
            chk_idle = 1'b0;
        end
        cap = pend;
        ch = cap_ch;
        pend = 1'b0;
        if (cap) chk("strobe_gap", 32'(output_sample), 0);
        if (output_sample && !cap) begin
            strobes++;
            ptr_m = pick(channel_mask, ptr_m, 1'b0);
            chk("chan", 32'(channel_select), ptr_m);
            cap_ch = ptr_m;
            pend = 1'b1;
        end
        if (mask_rand && $urandom_range(9) == 0) msk_nx = N'($urandom);
        channel_mask = msk_nx;
        enable = en_nx;
        clear = clr_now || (clr_on_cap && cap) || ($urandom_range(99) < clr_pct);
        if (clr_on_cap && cap) clr_on_cap = 1'b0;
        fifo_rd = rd_force || ($urandom_range(99) < rd_pct);
        w = '0;
        if (cap && !zero_bus) w = {cnt_pc[ch], 15'(bad_pos ? 3 : ch), bit_pc[ch]};
        sample_data = w;
        if (clear) begin
            model_clear();
            chk_idle = 1'b1;
        end else begin
            if (fifo_rd && q.size() > 0) chk("pop_data", fifo_data, q[0]);
            full_pre = q.size() == D;
            if (fifo_rd && q.size() > 0) void'(q.pop_front());
            if (cap) begin
                nw = (w[15:1] == 15'(ch)) && (w[31:16] != last_m[ch]);
                if (nw && !full_pre) begin
                    q.push_back(w);
                    last_m[ch] = w[31:16];
                end else if (nw) ovf_m = 1'b1;
                ptr_m = pick(channel_mask, ch, 1'b1);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        foreach (cnt_pc[i]) begin
            cnt_pc[i] = '0;
            bit_pc[i] = 1'b1;
            last_m[i] = '0;
        end
        #1 reset = 1'b0;
        #1;
        chk("rst_strobe", 32'(output_sample), 0);
        chk("rst_sel", 32'(channel_select), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", fifo_data, 0);
        @(negedge clk);
        reset = 1'b1;

        // 1: two channels, one fresh sample each
        cnt_pc[0] = 16'd1;
        cnt_pc[2] = 16'd1;
        msk_nx = 4'b0101;
        en_nx = 1'b1;
        run(14);
        chk("t1_count", 32'(fifo_count), 2);
        chk("t1_head0", fifo_data, 32'h0001_0001);
        rd_force = 1'b1;
        step();
        rd_force = 1'b0;
        step();
        chk("t1_head1", fifo_data, 32'h0001_0005);
        rd_force = 1'b1;
        step();
        rd_force = 1'b0;

        // 2: ch2 count steps, duplicates suppressed
        cnt_pc[2] = 16'd2;
        run(6);
        cnt_pc[2] = 16'd3;
        run(8);
        chk("t2_count", 32'(fifo_count), 2);
        chk("t2_head", fifo_data, 32'h0002_0005);
        rd_force = 1'b1;
        step();
        rd_force = 1'b0;
        step();
        chk("t2_head2", fifo_data, 32'h0003_0005);
        rd_force = 1'b1;
        step();
        rd_force = 1'b0;

        // 3: fill, overflow, then retry after one pop
        msk_nx = 4'b1111;
        foreach (cnt_pc[i]) cnt_pc[i] = 16'd7;
        run(14);
        chk("t3_full", 32'(fifo_full), 1);
        chk("t3_ovf0", 32'(overflow), 0);
        cnt_pc[0] = 16'd8;
        run(10);
        chk("t3_ovf1", 32'(overflow), 1);
        chk("t3_count", 32'(fifo_count), 4);
        rd_force = 1'b1;
        step();
        rd_force = 1'b0;
        run(10);
        chk("t3_refill", 32'(fifo_count), 4);
        chk("t3_sticky", 32'(overflow), 1);
        rd_pct = 100;
        run(6);
        rd_pct = 0;
        chk("t3_drained", 32'(fifo_empty), 1);

        // 4: position mismatch and idle bus are dropped
        clr_now = 1'b1;
        step();
        clr_now = 1'b0;
        msk_nx = 4'b0010;
        cnt_pc[1] = 16'd9;
        bad_pos = 1'b1;
        run(8);
        chk("t4_badpos", 32'(fifo_count), 0);
        bad_pos = 1'b0;
        zero_bus = 1'b1;
        run(6);
        chk("t4_zero", 32'(fifo_count), 0);
        zero_bus = 1'b0;
        run(6);
        chk("t4_later", 32'(fifo_count), 1);
        chk("t4_word", fifo_data, 32'h0009_0003);

        // 5: counter wrap, then clear during capture
        rd_pct = 100;
        run(3);
        rd_pct = 0;
        msk_nx = 4'b0001;
        cnt_pc[0] = 16'hFFFF;
        run(6);
        cnt_pc[0] = 16'h0000;
        run(6);
        chk("t5_wrap_count", 32'(fifo_count), 2);
        chk("t5_wrap_head", fifo_data, 32'hFFFF_0001);
        cnt_pc[0] = 16'd1;
        clr_on_cap = 1'b1;
        for (int i = 0; i < 10 && clr_on_cap; i++) step();
        chk("t5_clear_hit", 32'(clr_on_cap), 0);
        step();
        chk("t5_count", 32'(fifo_count), 0);

        // 6: async reset while a strobe is out
        run(2);
        for (int i = 0; i < 10 && !pend; i++) step();
        chk("t6_in_issue", 32'(output_sample), 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_strobe", 32'(output_sample), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_count", 32'(fifo_count), 0);
        chk("t6_empty", 32'(fifo_empty), 1);
        model_clear();
        ptr_m = 0;
        @(negedge clk);
        reset = 1'b1;
        run(8);
        chk("t6_restart", 32'(fifo_count), 1);

        // randomized traffic
        mask_rand = 1'b1;
        rd_pct = 40;
        clr_pct = 2;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(9) == 0) cnt_pc[$urandom_range(N - 1)] = 16'($urandom_range(3));
            if ($urandom_range(9) == 0) bit_pc[$urandom_range(N - 1)] = 1'($urandom);
            if ($urandom_range(19) == 0) en_nx = !en_nx;
            step();
        end
        mask_rand = 1'b0;
        clr_pct = 0;
        en_nx = 1'b0;
        run(6);
        chk("end_idle", 32'(busy), 0);
        chk("liveness", 32'(strobes > 100), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
